// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the transmit/receive frame schedulers:
// FSM state encoding and default timing constants.
package tx_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_e;

  localparam int DEFAULT_IFG_CYCLES     = 12;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after rr_ptr,
// wrapping, so the previous winner gets lowest priority.
module tx_frame_scheduler_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      rr_ptr_i,
  output logic               valid_o,
  output logic [PW-1:0]      winner_o,
  output logic [NUM_REQ-1:0] grant_o
);

  int          idx;
  logic [PW-1:0] idx_w;

  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    grant_o  = '0;
    idx      = 0;
    idx_w    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(rr_ptr_i) + k) % NUM_REQ;
      idx_w = PW'(idx);
      if (!valid_o && req_i[idx_w]) begin
        valid_o        = 1'b1;
        winner_o       = idx_w;
        grant_o[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one frame transmitter among NUM_REQ requesters,
// with payload latch, inter-frame gap and a watchdog for a missing tx_done.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int IFG_CYCLES     = DEFAULT_IFG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [15:0]               frames_sent
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max2(IFG_CYCLES, TIMEOUT_CYCLES) + 1);

  sched_state_e        state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                tx_en_q, tx_en_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         frames_sent_q, frames_sent_d;
  logic [CW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [CW-1:0]       gap_cnt_q, gap_cnt_d;

  logic                arb_valid;
  logic [PW-1:0]       arb_winner;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [DATA_W-1:0]   payload [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
    assign payload[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  tx_frame_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner),
    .grant_o  (arb_grant)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    done_d        = '0;
    tx_en_d       = 1'b0;
    tx_data_d     = tx_data_q;
    timeout_d     = 1'b0;
    frames_sent_d = frames_sent_q;
    tmo_cnt_d     = tmo_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d   = arb_grant;
          tx_data_d = payload[arb_winner];
          rr_ptr_d  = arb_winner;
          tx_en_d   = 1'b1;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // tx_done takes precedence over a watchdog expiry in the same cycle
        if (tx_done) begin
          done_d        = grant_q;
          frames_sent_d = frames_sent_q + 16'd1;
          grant_d       = '0;
          gap_cnt_d     = CW'(IFG_CYCLES - 1);
          state_d       = ST_GAP;
        end else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          gap_cnt_d = CW'(IFG_CYCLES - 1);
          state_d   = ST_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= PW'(NUM_REQ - 1);
      grant_q       <= '0;
      done_q        <= '0;
      tx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      frames_sent_q <= '0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      frames_sent_q <= frames_sent_d;
      tmo_cnt_q     <= tmo_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign tx_en       = tx_en_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign frames_sent = frames_sent_q;

endmodule
